// File: rtl/ip_tx_pkg.sv
// Shared types and constants for the IP transmit arbiter.
package ip_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_t;

  localparam logic [7:0] PROTO_UDP  = 8'd17;
  localparam logic [7:0] PROTO_TCP  = 8'd6;
  localparam logic [3:0] IP_VERSION = 4'd4;
  localparam logic [3:0] IP_IHL     = 4'd5;

  // Per-packet header fields captured from the winning requester.
  typedef struct packed {
    logic [15:0] len;
    logic [15:0] checksum;
    logic [31:0] src_ip;
    logic [31:0] dest_ip;
  } hdr_t;

  function automatic logic [7:0] proto_of(input logic is_tcp);
    return is_tcp ? PROTO_TCP : PROTO_UDP;
  endfunction

endpackage

// File: rtl/ip_tx_arbiter_if.sv
// Requester-side bundle between one transport encoder and the arbiter.
// master = transport encoder, slave = arbiter.
interface ip_tx_arbiter_if;
  logic        req;
  logic [15:0] len;
  logic [15:0] checksum;
  logic [31:0] src_ip;
  logic [31:0] dest_ip;
  logic [31:0] data;
  logic        data_av;
  logic        gnt;
  logic        done;

  modport master (
    output req, len, checksum, src_ip, dest_ip, data, data_av,
    input  gnt, done
  );

  modport slave (
    input  req, len, checksum, src_ip, dest_ip, data, data_av,
    output gnt, done
  );
endinterface

// File: rtl/ip_tx_arbiter_rr_arb2.sv
// Two-way round-robin grant decision; purely combinational.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic       valid,
  output logic       sel
);

  // A lone requester wins; on a tie the one that was not served last wins.
  always_comb begin
    valid = |req;
    sel   = 1'b0;
    case (req)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~rr_last;
      default: sel = 1'b0;
    endcase
  end

endmodule

// File: rtl/ip_tx_arbiter.sv
// Shares one IP encoder between the UDP (port 0) and TCP (port 1) transport
// encoders: round-robin grant, encoder sequencing (reset, start, stream, fin),
// header/data muxing and the IP identification counter.
// Optional build macro IP_ARB_TIMEOUT_EN adds a RUN-state watchdog and the
// timeout_err output.
module ip_tx_arbiter
  import ip_tx_pkg::*;
#(
  parameter logic [15:0] ID_INIT = 16'h0000,
  parameter logic [7:0]  TTL     = 8'h40,
  parameter logic [7:0]  TOS     = 8'h00
`ifdef IP_ARB_TIMEOUT_EN
  ,
  parameter int          TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  ip_tx_arbiter_if.slave        udp,
  ip_tx_arbiter_if.slave        tcp,
  output logic                  enc_reset,
  output logic                  enc_start,
  output logic                  enc_check,
  output logic [7:0]            enc_protocol,
  output logic [15:0]           enc_identification,
  output logic [7:0]            enc_ttl,
  output logic [7:0]            enc_tos,
  output logic [15:0]           enc_len,
  output logic [15:0]           enc_checksum,
  output logic [31:0]           enc_src_ip,
  output logic [31:0]           enc_dest_ip,
  output logic [31:0]           enc_data,
  output logic                  enc_data_av,
  input  logic                  enc_fin,
  output logic                  busy
`ifdef IP_ARB_TIMEOUT_EN
  ,
  output logic                  timeout_err
`endif
);

  state_t      state;
  state_t      state_nxt;
  logic        sel;
  logic        rr_last;
  logic        run_first;
  logic [15:0] ident;
  hdr_t        hdr;
  logic        arb_valid;
  logic        arb_sel;
  logic        hdr_on;
  logic        in_run;
  logic        active;

  rr_arb2 u_arb (
    .req     ({tcp.req, udp.req}),
    .rr_last (rr_last),
    .valid   (arb_valid),
    .sel     (arb_sel)
  );

`ifdef IP_ARB_TIMEOUT_EN
  logic [15:0] run_cnt;

  // Watchdog: cleared on the way into RUN, counts every RUN cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt <= '0;
    end else if (state == CLR) begin
      run_cnt <= '0;
    end else if (state == RUN) begin
      run_cnt <= run_cnt + 16'd1;
    end
  end

  assign timeout_err = (state == ABORT);
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decision.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (arb_valid) state_nxt = CLR;
      CLR:   state_nxt = RUN;
      RUN: begin
        if (enc_fin) begin
          state_nxt = DONE;
        end
`ifdef IP_ARB_TIMEOUT_EN
        else if (run_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = ABORT;
        end
`endif
      end
      DONE:    state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: owner, fairness history, first-RUN marker, identification.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel       <= 1'b0;
      rr_last   <= 1'b1;
      run_first <= 1'b0;
      ident     <= ID_INIT;
    end else begin
      run_first <= (state == CLR);
      if (state == IDLE && arb_valid) begin
        sel <= arb_sel;
      end
      if (state == DONE) begin
        rr_last <= sel;
        ident   <= ident + 16'd1;
      end
      if (state == ABORT) begin
        rr_last <= sel;
      end
    end
  end

  // Header snapshot taken on grant; later requester changes are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && arb_valid) begin
      hdr <= arb_sel ? hdr_t'{tcp.len, tcp.checksum, tcp.src_ip, tcp.dest_ip}
                     : hdr_t'{udp.len, udp.checksum, udp.src_ip, udp.dest_ip};
    end
  end

  assign hdr_on = (state != IDLE);
  assign in_run = (state == RUN);
  assign active = (state == CLR) || (state == RUN);

  assign udp.gnt  = active & ~sel;
  assign tcp.gnt  = active &  sel;
  assign udp.done = (state == DONE) & ~sel;
  assign tcp.done = (state == DONE) &  sel;

  assign enc_reset          = ~reset | (state == CLR) | (state == ABORT);
  assign enc_start          = in_run & run_first;
  assign enc_check          = hdr_on & sel;
  assign enc_protocol       = hdr_on ? proto_of(sel) : 8'd0;
  assign enc_identification = ident;
  assign enc_ttl            = TTL;
  assign enc_tos            = TOS;
  assign enc_len            = hdr_on ? hdr.len      : 16'd0;
  assign enc_checksum       = hdr_on ? hdr.checksum : 16'd0;
  assign enc_src_ip         = hdr_on ? hdr.src_ip   : 32'd0;
  assign enc_dest_ip        = hdr_on ? hdr.dest_ip  : 32'd0;
  assign enc_data           = in_run ? (sel ? tcp.data : udp.data) : 32'd0;
  assign enc_data_av        = in_run & (sel ? tcp.data_av : udp.data_av);
  assign busy               = hdr_on;

endmodule
